// File: rtl/subckt_seq_pkg.sv
// Shared constants and helpers for the sub-circuit activity sequencer.
package subckt_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_APPLY  = 3'd1;
    localparam state_t S_HOLD   = 3'd2;
    localparam state_t S_SAMPLE = 3'd3;
    localparam state_t S_DONE   = 3'd4;

    localparam logic ORDER_BIN  = 1'b0;
    localparam logic ORDER_GRAY = 1'b1;

    // Saturating add; callers pass their counter maximum (counters up to 32 bits).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

endpackage

// File: rtl/subckt_activity_sequencer_if.sv
// Host/sub-circuit side bundle of the activity sequencer.
interface subckt_activity_sequencer_if #(
    parameter int NIN   = 4,
    parameter int CNT_W = 16
);
    logic             start_i;
    logic             gray_i;
    logic             abort_i;
    logic             res_i;
    logic [NIN-1:0]   vec_o;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] ones_o;
    logic [CNT_W-1:0] out_tog_o;
    logic [CNT_W-1:0] in_tog_o;

    modport master (
        output start_i, gray_i, abort_i, res_i,
        input  vec_o, busy_o, done_o, ones_o, out_tog_o, in_tog_o
    );

    modport slave (
        input  start_i, gray_i, abort_i, res_i,
        output vec_o, busy_o, done_o, ones_o, out_tog_o, in_tog_o
    );
endinterface

// File: rtl/subckt_vec_gen.sv
// Sweep index/pass counters with binary or Gray mapping and the bit delta to the next vector.
module subckt_vec_gen
    import subckt_seq_pkg::*;
#(
    parameter int NIN    = 4,
    parameter int PASSES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       gray,
    input  logic                       step,
    output logic [NIN-1:0]             vec,
    output logic [$clog2(NIN+1)-1:0]   delta,
    output logic                       last
);
    localparam int DW = $clog2(NIN + 1);
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    logic [NIN-1:0] idx, idx_nx, vec_nx;
    logic [PW-1:0]  pass;
    logic           order_q;

    function automatic logic [NIN-1:0] map(input logic [NIN-1:0] k, input logic ord);
        return (ord == ORDER_BIN) ? k : (k ^ (k >> 1));
    endfunction

    assign idx_nx = idx + 1'b1;
    assign vec    = map(idx, order_q);
    assign vec_nx = map(idx_nx, order_q);
    assign last   = (&idx) && (pass == PW'(PASSES - 1));

    // Delta toward the next vector, including the wrap back to index 0.
    always_comb begin
        delta = '0;
        for (int i = 0; i < NIN; i++)
            delta = delta + DW'(vec[i] ^ vec_nx[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            pass    <= '0;
            order_q <= ORDER_BIN;
        end else if (clear) begin
            idx     <= '0;
            pass    <= '0;
            order_q <= gray ? ORDER_GRAY : ORDER_BIN;
        end else if (step) begin
            idx <= idx_nx;
            if (&idx)
                pass <= pass + 1'b1;
        end
    end

endmodule

// File: rtl/subckt_activity_sequencer.sv
// Sweeps all input vectors of a sub-circuit, holds each SETTLE+1 cycles, and
// accumulates output ones, output toggles and input-bit toggles.
module subckt_activity_sequencer
    import subckt_seq_pkg::*;
#(
    parameter int NIN    = 4,
    parameter int SETTLE = 1,
    parameter int PASSES = 1,
    parameter int CNT_W  = 16
) (
    input logic                        clk,
    input logic                        rst,
    subckt_activity_sequencer_if.slave bus
);
    localparam int          DW      = $clog2(NIN + 1);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    state_t           state, state_nx;
    logic [3:0]       hold_cnt;
    logic             first_q, prev_q;
    logic [CNT_W-1:0] ones_q, otog_q, itog_q;
    logic [NIN-1:0]   vec;
    logic [DW-1:0]    delta;
    logic             last, busy, accept, smp, step;

    assign busy   = (state == S_APPLY) || (state == S_HOLD) || (state == S_SAMPLE);
    assign accept = (state == S_IDLE) && bus.start_i && !bus.abort_i;
    // With no settle time the APPLY cycle is the whole window and samples itself.
    assign smp    = !bus.abort_i && ((state == S_SAMPLE) || (state == S_APPLY && SETTLE == 0));
    assign step   = smp && !last;

    subckt_vec_gen #(.NIN(NIN), .PASSES(PASSES)) u_vec_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .gray  (bus.gray_i),
        .step  (step),
        .vec   (vec),
        .delta (delta),
        .last  (last)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = S_APPLY;
            S_APPLY: begin
                if (SETTLE == 0)      state_nx = last ? S_DONE : S_APPLY;
                else if (SETTLE == 1) state_nx = S_SAMPLE;
                else                  state_nx = S_HOLD;
            end
            // APPLY + (SETTLE-1) HOLD cycles + SAMPLE = SETTLE+1 cycles per vector
            S_HOLD:   if (hold_cnt == 4'(SETTLE - 2)) state_nx = S_SAMPLE;
            S_SAMPLE: state_nx = last ? S_DONE : S_APPLY;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (busy && bus.abort_i)
            state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            first_q  <= 1'b1;
            prev_q   <= 1'b0;
            ones_q   <= '0;
            otog_q   <= '0;
            itog_q   <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= (state == S_HOLD && !bus.abort_i) ? hold_cnt + 1'b1 : 4'd0;
            if (accept) begin
                first_q <= 1'b1;
                ones_q  <= '0;
                otog_q  <= '0;
                itog_q  <= '0;
            end else if (smp) begin
                ones_q <= CNT_W'(sat_add(32'(ones_q), 32'(bus.res_i), CNT_MAX));
                if (!first_q && (bus.res_i != prev_q))
                    otog_q <= CNT_W'(sat_add(32'(otog_q), 32'd1, CNT_MAX));
                if (step)
                    itog_q <= CNT_W'(sat_add(32'(itog_q), 32'(delta), CNT_MAX));
                prev_q  <= bus.res_i;
                first_q <= 1'b0;
            end
        end
    end

    assign bus.vec_o     = busy ? vec : '0;
    assign bus.busy_o    = busy;
    assign bus.done_o    = (state == S_DONE);
    assign bus.ones_o    = ones_q;
    assign bus.out_tog_o = otog_q;
    assign bus.in_tog_o  = itog_q;

endmodule
